// File: rtl/seq_alu.sv
// Sequential ALU feeding the accumulator: PASS_B/ADD/SUB in one cycle, MUL as N-cycle shift-add.
// Define SEQ_ALU_MUL_EN to build the multiplier; otherwise op 11 behaves as PASS_B.
module seq_alu #(
    parameter int unsigned N = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] alu_out,
    output logic         alu_to_ac,
    output logic         busy,
    output logic         z_flag
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [1:0] MUL_RUN = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'b11;
    localparam int unsigned CW     = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [N-1:0]  prod_q, prod_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sum;
`endif

    logic [1:0]   state_q, state_d;
    logic [N-1:0] alu_out_q, alu_out_d;
    logic         z_q, z_d;
    logic [N-1:0] result;
    logic         load;

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        z_d       = z_q;
        result    = '0;
        load      = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        sum       = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef SEQ_ALU_MUL_EN
                    if (op == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = b;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = MUL_RUN;
                    end else
`endif
                    begin
                        unique case (op)
                            OP_ADD:  result = a + b;
                            OP_SUB:  result = a - b;
                            default: result = b;
                        endcase
                        load    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
`ifdef SEQ_ALU_MUL_EN
            MUL_RUN: begin
                prod_d   = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Always exactly N iterations; the last one commits the product.
                if (cnt_q == CW'(N - 1)) begin
                    result  = sum;
                    load    = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            alu_out_d = result;
            z_d       = (result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            alu_out_q <= '0;
            z_q       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            z_q       <= z_d;
`ifdef SEQ_ALU_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign alu_out   = alu_out_q;
    assign alu_to_ac = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign z_flag    = z_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu; MUL steps are built only with SEQ_ALU_MUL_EN.
module tb_seq_alu;
    localparam int unsigned N = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] alu_out;
    logic         alu_to_ac;
    logic         busy;
    logic         z_flag;

    int checks = 0;
    int errors = 0;

    seq_alu #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .alu_out   (alu_out),
        .alu_to_ac (alu_to_ac),
        .busy      (busy),
        .z_flag    (z_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    task automatic single(input string tag, input logic [1:0] o, input logic [N-1:0] av,
                          input logic [N-1:0] bv, input logic [31:0] exp, input logic [31:0] expz);
        issue(o, av, bv);
        check({tag, " strobe"}, alu_to_ac, 1);
        check({tag, " result"}, alu_out, exp);
        check({tag, " z"}, z_flag, expz);
        check({tag, " busy_done"}, busy, 1);
        tick();
        check({tag, " strobe_off"}, alu_to_ac, 0);
        check({tag, " busy_off"}, busy, 0);
        check({tag, " hold"}, alu_out, exp);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst alu_out", alu_out, 0);
        check("rst strobe", alu_to_ac, 0);
        check("rst busy", busy, 0);
        check("rst z", z_flag, 0);

        single("add 5+7", 2'b01, 15'd5, 15'd7, 12, 0);
        single("sub 3-3", 2'b10, 15'd3, 15'd3, 0, 1);
        single("sub 2-5", 2'b10, 15'd2, 15'd5, 32765, 0);
        single("pass 123", 2'b00, 15'd77, 15'd123, 123, 0);
        single("add wrap", 2'b01, 15'd32767, 15'd3, 2, 0);

        // start held through DONE must be dropped; DONE always returns to IDLE.
        issue(2'b01, 15'd1, 15'd2);
        check("drop accept", alu_out, 3);
        start = 1'b1;
        op    = 2'b00;
        b     = 15'd99;
        tick();
        start = 1'b0;
        check("drop strobe", alu_to_ac, 0);
        check("drop busy", busy, 0);
        check("drop result", alu_out, 3);

        single("sub 3-3 again", 2'b10, 15'd3, 15'd3, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst z clear", z_flag, 0);

`ifdef SEQ_ALU_MUL_EN
        issue(2'b11, 15'd300, 15'd100);
        check("mul0 busy", busy, 1);
        check("mul0 strobe", alu_to_ac, 0);
        for (int i = 1; i < 15; i++) begin
            tick();
            check("mul run busy", busy, 1);
            check("mul run strobe", alu_to_ac, 0);
        end
        tick();
        check("mul 300x100 strobe", alu_to_ac, 1);
        check("mul 300x100 result", alu_out, 30000);
        check("mul 300x100 busy", busy, 1);
        check("mul 300x100 z", z_flag, 0);
        tick();
        check("mul end strobe", alu_to_ac, 0);
        check("mul end busy", busy, 0);

        issue(2'b11, 15'd200, 15'd200);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("mul2 strobe", alu_to_ac, (i == 15) ? 1 : 0);
        end
        check("mul 200x200 result", alu_out, 7232);
        tick();

        // ADD requested mid-multiply must be ignored.
        issue(2'b11, 15'd300, 15'd100);
        for (int i = 1; i <= 15; i++) begin
            if (i == 4) begin
                start = 1'b1;
                op    = 2'b01;
                a     = 15'd1;
                b     = 15'd1;
            end
            tick();
            start = 1'b0;
            check("busy rej strobe", alu_to_ac, (i == 15) ? 1 : 0);
        end
        check("busy rej product", alu_out, 30000);
        tick();
        check("busy rej after strobe", alu_to_ac, 0);
        check("busy rej after result", alu_out, 30000);
        single("add 1+1", 2'b01, 15'd1, 15'd1, 2, 0);

        issue(2'b11, 15'd300, 15'd100);
        for (int i = 1; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst alu_out", alu_out, 0);
        check("mid rst strobe", alu_to_ac, 0);
        check("mid rst busy", busy, 0);
        check("mid rst z", z_flag, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post rst strobe", alu_to_ac, 0);
            check("post rst busy", busy, 0);
        end
        single("add 0+0", 2'b01, 15'd0, 15'd0, 0, 1);
`else
        single("op11 pass", 2'b11, 15'd9, 15'd4, 4, 0);
        tick();
        check("op11 idle busy", busy, 0);
        check("op11 idle strobe", alu_to_ac, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst after op11", alu_out, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
